// File: rtl/spi_bus_pkg.sv
// rtl/spi_bus_pkg.sv - shared types and constants for the SPI transfer scheduler
package spi_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_BYTE,
        ST_SHIFT,
        ST_RELEASE
    } state_e;

    localparam logic DEV_FLASH = 1'b0;
    localparam logic DEV_TF    = 1'b1;

    localparam logic REQ_CPU   = 1'b0;
    localparam logic REQ_BOOT  = 1'b1;

    function automatic logic [1:0] req_onehot(input logic r);
        return r ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - mode-0 MSB-first byte shifter with SCK divider
module spi_byte_shifter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [7:0]       tx_byte,
    input  logic [DIV_W-1:0] div,
    input  logic             sdi,
    output logic             sck_d,
    output logic             sdo_d,
    output logic             done,
    output logic [7:0]       rx_byte_d
);
    logic             busy_q, busy_d;
    logic [3:0]       half_q, half_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             sample_q, sample_d;

    always_comb begin
        busy_d   = busy_q;
        half_d   = half_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        shreg_d  = shreg_q;
        sample_d = sample_q;
        done     = 1'b0;
        if (start) begin
            busy_d  = 1'b1;
            half_d  = 4'd0;
            cnt_d   = '0;
            div_d   = div;
            shreg_d = tx_byte;
        end else if (busy_q) begin
            if (cnt_q == div_q) begin
                cnt_d = '0;
                // even half ends on the rising SCK edge, odd half on the falling one
                if (!half_q[0]) begin
                    sample_d = sdi;
                end else begin
                    shreg_d = {shreg_q[6:0], sample_q};
                end
                if (half_q == 4'd15) begin
                    busy_d = 1'b0;
                    done   = 1'b1;
                end else begin
                    half_d = half_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        sck_d     = busy_d & half_d[0];
        sdo_d     = busy_d & shreg_d[7];
        rx_byte_d = shreg_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q   <= 1'b0;
            half_q   <= 4'd0;
            cnt_q    <= '0;
            div_q    <= '0;
            shreg_q  <= 8'h00;
            sample_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            half_q   <= half_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shreg_q  <= shreg_d;
            sample_q <= sample_d;
        end
    end

endmodule

// File: rtl/spi_bus_sched.sv
// rtl/spi_bus_sched.sv - round-robin scheduler of two byte requesters onto flash/TF SPI ports
module spi_bus_sched
    import spi_bus_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             FastClk,
    input  logic             nReset,
    input  logic [DIV_W-1:0] ClkDiv,
    input  logic [1:0]       Req,
    input  logic [1:0]       Dev,
    output logic [1:0]       Gnt,
    input  logic [1:0]       TxValid,
    input  logic [15:0]      TxData,
    output logic [1:0]       TxReady,
    output logic [1:0]       RxValid,
    output logic [7:0]       RxData,
    output logic             nFlashSel,
    output logic             SPIClk,
    output logic             SPIDo,
    input  logic             SPIDi,
    output logic             nTFSel,
    output logic             TFClk,
    output logic             TFDo,
    input  logic             TFDi
);
    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             dev_q, dev_d;
    logic             last_q, last_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       tx_ready_q, tx_ready_d;
    logic [1:0]       rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             nflash_q, nflash_d;
    logic             ntf_q, ntf_d;
    logic             spi_clk_q, spi_clk_d;
    logic             spi_do_q, spi_do_d;
    logic             tf_clk_q, tf_clk_d;
    logic             tf_do_q, tf_do_d;

    logic             own_req;
    logic             own_tx_valid;
    logic             own_tx_ready;
    logic             start;
    logic             active;
    logic [7:0]       tx_byte;
    logic             sh_sck_d, sh_sdo_d, sh_done, sh_sdi;
    logic [7:0]       sh_rx_byte;

    assign own_req      = owner_q ? Req[1] : Req[0];
    assign own_tx_valid = owner_q ? TxValid[1] : TxValid[0];
    assign own_tx_ready = owner_q ? tx_ready_q[1] : tx_ready_q[0];
    assign tx_byte      = owner_q ? TxData[15:8] : TxData[7:0];
    assign sh_sdi       = (dev_q == DEV_TF) ? TFDi : SPIDi;

    spi_byte_shifter #(.DIV_W(DIV_W)) u_shifter (
        .clk       (FastClk),
        .resetn    (nReset),
        .start     (start),
        .tx_byte   (tx_byte),
        .div       (ClkDiv),
        .sdi       (sh_sdi),
        .sck_d     (sh_sck_d),
        .sdo_d     (sh_sdo_d),
        .done      (sh_done),
        .rx_byte_d (sh_rx_byte)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dev_d   = dev_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|Req) begin
                    // on a tie the requester not granted last wins
                    owner_d = (Req == 2'b11) ? ~last_q : Req[1];
                    dev_d   = owner_d ? Dev[1] : Dev[0];
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == ClkDiv) begin
                    cnt_d = '0;
                    if (own_req) begin
                        state_d = ST_WAIT_BYTE;
                    end else begin
                        state_d = ST_RELEASE;
                        last_d  = owner_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_BYTE: begin
                if (own_tx_valid && own_tx_ready) begin
                    start   = 1'b1;
                    state_d = ST_SHIFT;
                end else if (!own_req) begin
                    cnt_d   = '0;
                    last_d  = owner_q;
                    state_d = ST_RELEASE;
                end
            end
            ST_SHIFT: begin
                // stay one extra cycle so the RxValid pulse precedes TxReady
                if (|rx_valid_q) begin
                    state_d = ST_WAIT_BYTE;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == ClkDiv) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        active     = (state_d == ST_SETUP) || (state_d == ST_WAIT_BYTE) || (state_d == ST_SHIFT);
        gnt_d      = active ? req_onehot(owner_d) : 2'b00;
        tx_ready_d = (state_d == ST_WAIT_BYTE && Req[owner_d]) ? req_onehot(owner_d) : 2'b00;
        rx_valid_d = sh_done ? req_onehot(owner_q) : 2'b00;
        rx_data_d  = sh_done ? sh_rx_byte : rx_data_q;
        nflash_d   = !(active && dev_d == DEV_FLASH);
        ntf_d      = !(active && dev_d == DEV_TF);
        spi_clk_d  = active && dev_d == DEV_FLASH && sh_sck_d;
        spi_do_d   = active && dev_d == DEV_FLASH && sh_sdo_d;
        tf_clk_d   = active && dev_d == DEV_TF && sh_sck_d;
        tf_do_d    = active && dev_d == DEV_TF && sh_sdo_d;
    end

    always_ff @(posedge FastClk) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            owner_q    <= REQ_CPU;
            dev_q      <= DEV_FLASH;
            last_q     <= REQ_CPU;
            cnt_q      <= '0;
            gnt_q      <= 2'b00;
            tx_ready_q <= 2'b00;
            rx_valid_q <= 2'b00;
            rx_data_q  <= 8'h00;
            nflash_q   <= 1'b1;
            ntf_q      <= 1'b1;
            spi_clk_q  <= 1'b0;
            spi_do_q   <= 1'b0;
            tf_clk_q   <= 1'b0;
            tf_do_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            dev_q      <= dev_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            nflash_q   <= nflash_d;
            ntf_q      <= ntf_d;
            spi_clk_q  <= spi_clk_d;
            spi_do_q   <= spi_do_d;
            tf_clk_q   <= tf_clk_d;
            tf_do_q    <= tf_do_d;
        end
    end

    assign Gnt       = gnt_q;
    assign TxReady   = tx_ready_q;
    assign RxValid   = rx_valid_q;
    assign RxData    = rx_data_q;
    assign nFlashSel = nflash_q;
    assign SPIClk    = spi_clk_q;
    assign SPIDo     = spi_do_q;
    assign nTFSel    = ntf_q;
    assign TFClk     = tf_clk_q;
    assign TFDo      = tf_do_q;

endmodule
